tone_sequencer: RTL
===================

TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter VOICES, default 2, number of square-wave voices (1..4).
REQ-002 SHALL have parameter SEQ_LEN, default 8, steps per sequence (power of two, 8..32).
REQ-003 SHALL have parameter FRAMES_PER_STEP, default 128, frames per step at tempo 0 (power of two, 16..256).
REQ-004 SHALL have parameter GATE_THR, default 10, envelope level at or below which voices are muted.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port line_tick  input  1  one-cycle pulse per scanline.
REQ-008 SHALL have port frame_tick  input  1  one-cycle pulse per frame.
REQ-009 SHALL have port run  input  1  level: 1 = play, 0 = stop.
REQ-010 SHALL have port tempo  input  2  step-length divider select.
REQ-011 SHALL have port voice_wave  output  VOICES  raw square wave per voice.
REQ-012 SHALL have port mix  output  clog2(VOICES+1)  count of voices whose raw wave is high, when the gate is open.
REQ-013 SHALL have port sound  output  1  1 when mix is nonzero.
REQ-014 SHALL have port step_idx  output  clog2(SEQ_LEN)  current step, for beat-synced visuals.
REQ-015 SHALL have port step_strobe  output  1  one-cycle pulse on every step advance.
REQ-016 SHALL have port env_level  output  5  current envelope level.
REQ-017 SHALL have port playing  output  1  1 in PLAY or FADE.

Function
REQ-018 SHALL implement states IDLE, PLAY and FADE.
REQ-019 SHALL transition IDLE->PLAY when run=1; on entry, step_idx=0, env_level=31 and the frame count is cleared.
REQ-020 SHALL transition PLAY->FADE when run=0, and FADE->PLAY when run=1 with step_idx and env_level preserved.
REQ-021 SHALL transition FADE->IDLE in the cycle env_level reaches 0; IDLE forces step_idx=0 and voice_wave=0.
REQ-022 SHALL use note divisor table index 0..7 = 60,54,48,45,40,36,32,30 (C4..C5).
REQ-023 SHALL give voice v the divisor at index (step_idx + 2*v) mod 8.
REQ-024 SHALL update each voice on line_tick: if cnt >= div then cnt<=0 and wave toggles, else cnt<=cnt+1; wave period = 2*(div+1) line_ticks.
REQ-025 SHALL keep voice counters and phase across step changes (no reset); a counter above its new divisor toggles on the next line_tick.
REQ-026 SHALL, in PLAY, increment the frame count on each frame_tick; when it reaches (FRAMES_PER_STEP>>tempo)-1 on a frame_tick, the count SHALL clear, step_idx SHALL advance modulo SEQ_LEN, step_strobe SHALL pulse and env_level SHALL reload to 31.
REQ-027 SHALL sample tempo only at step boundaries.
REQ-028 SHALL decrement env_level by 1 on each frame_tick, saturating at 0, except in the cycle it reloads.
REQ-029 SHALL treat the gate as open when env_level > GATE_THR; mix, and hence sound, SHALL be 0 when the gate is closed.
REQ-030 SHALL register mix and sound, with one cycle of latency from voice_wave.
REQ-031 SHALL process a coincident line_tick and frame_tick in the same cycle, both taking effect.
REQ-032 SHALL freeze the frame count in FADE; voices SHALL keep toggling.

Reset
REQ-033 SHALL set, while rst_n=0 at posedge clk, state=IDLE and every counter, voice_wave, mix, sound, step_idx, step_strobe, env_level and playing to 0.
REQ-034 SHALL apply reset mid-operation on the next posedge, with no fade.

Configuration
REQ-035 SHALL, with TONE_SEQ_ENVELOPE_EN defined, provide the envelope, gate and FADE behaviour of REQ-020, REQ-021 and REQ-028 to REQ-032.
REQ-036 SHALL, with TONE_SEQ_ENVELOPE_EN undefined, hold env_level at 31 in PLAY and 0 in IDLE, keep the gate always open in PLAY, and go from PLAY directly to IDLE when run=0 (FADE unreachable).

Verification
REQ-037 SHALL cover: rst_n=0 for 4 cycles during PLAY -> all outputs 0 and playing=0 on the next cycle.
REQ-038 SHALL cover: run=1, step 0, line_tick pulses -> voice_wave[0] toggles every 61 line_ticks and voice_wave[1] every 49.
REQ-039 SHALL cover: tempo=0 and 128 frame_ticks -> step_strobe pulses once, step_idx=1, voice0 period 110, voice1 period 92 line_ticks.
REQ-040 SHALL cover: 21 frame_ticks after a step start -> env_level=10 and sound=0 from the following cycle.
REQ-041 SHALL cover: run=0 at env_level=20 -> FADE, and after 20 frame_ticks -> IDLE, step_idx=0, playing=0; repeated with the macro undefined -> IDLE on the next cycle.
REQ-042 SHALL cover: tempo=3 and step_idx=7 -> after 16 frame_ticks step_idx=0 (wrap), with a coincident line_tick and frame_tick both honoured.

Source files
------------

// File: rtl/tone_sequencer.sv
// Beat-stepped square-wave sequencer: VOICES tone generators walk a note table, one step per
// tempo-scaled frame count. Define TONE_SEQ_ENVELOPE_EN for the decaying envelope, gate and FADE.
module tone_sequencer #(
  parameter int unsigned VOICES          = 2,
  parameter int unsigned SEQ_LEN         = 8,
  parameter int unsigned FRAMES_PER_STEP = 128,
  parameter int unsigned GATE_THR        = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         line_tick,
  input  logic                         frame_tick,
  input  logic                         run,
  input  logic [1:0]                   tempo,
  output logic [VOICES-1:0]            voice_wave,
  output logic [$clog2(VOICES+1)-1:0]  mix,
  output logic                         sound,
  output logic [$clog2(SEQ_LEN)-1:0]   step_idx,
  output logic                         step_strobe,
  output logic [4:0]                   env_level,
  output logic                         playing
);

  localparam int unsigned MixW   = $clog2(VOICES + 1);
  localparam int unsigned StepW  = $clog2(SEQ_LEN);
  localparam int unsigned FrameW = $clog2(FRAMES_PER_STEP);

  typedef enum logic [1:0] {StIdle, StPlay, StFade} state_e;

  state_e              state_q, state_d;
  logic [StepW-1:0]    step_q, step_d;
  logic [FrameW-1:0]   frame_q, frame_d, frame_last;
  logic [1:0]          tempo_q, tempo_d;
  logic [4:0]          env_q, env_d;
  logic                strobe_q, strobe_d;
  logic [5:0]          cnt_q [VOICES];
  logic [5:0]          cnt_d [VOICES];
  logic [VOICES-1:0]   wave_q, wave_d;
  logic [MixW-1:0]     mix_q, mix_d;
  logic                sound_q, sound_d;
  logic                gate_open;

  function automatic logic [5:0] note_div(input logic [2:0] idx);
    case (idx)
      3'd0:    note_div = 6'd60;
      3'd1:    note_div = 6'd54;
      3'd2:    note_div = 6'd48;
      3'd3:    note_div = 6'd45;
      3'd4:    note_div = 6'd40;
      3'd5:    note_div = 6'd36;
      3'd6:    note_div = 6'd32;
      default: note_div = 6'd30;
    endcase
  endfunction

  assign frame_last = FrameW'((FRAMES_PER_STEP >> tempo_q) - 1);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    frame_d  = frame_q;
    tempo_d  = tempo_q;
    env_d    = env_q;
    strobe_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StPlay;
          step_d  = '0;
          frame_d = '0;
          env_d   = 5'd31;
          tempo_d = tempo;
        end
      end
      StPlay: begin
        if (frame_tick) begin
          if (frame_q == frame_last) begin
            // Tempo is only picked up here so a step never changes length midway.
            frame_d  = '0;
            step_d   = step_q + 1'b1;
            strobe_d = 1'b1;
            env_d    = 5'd31;
            tempo_d  = tempo;
          end else begin
            frame_d = frame_q + 1'b1;
`ifdef TONE_SEQ_ENVELOPE_EN
            if (env_q != 5'd0) env_d = env_q - 1'b1;
`endif
          end
        end
        if (!run) begin
`ifdef TONE_SEQ_ENVELOPE_EN
          state_d = StFade;
`else
          state_d = StIdle;
          step_d  = '0;
          frame_d = '0;
          env_d   = 5'd0;
`endif
        end
      end
`ifdef TONE_SEQ_ENVELOPE_EN
      StFade: begin
        if (frame_tick && env_q != 5'd0) env_d = env_q - 1'b1;
        if (run) begin
          state_d = StPlay;
        end else if (env_d == 5'd0) begin
          state_d = StIdle;
          step_d  = '0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

`ifdef TONE_SEQ_ENVELOPE_EN
  assign gate_open = 32'(env_q) > GATE_THR;
`else
  // env is pinned at 31 in PLAY; the PLAY term keeps the gate open for any threshold.
  assign gate_open = (state_q == StPlay) || (32'(env_q) > GATE_THR);
`endif

  always_comb begin
    logic [MixW-1:0] pop;
    logic [5:0]      div;
    pop    = '0;
    div    = '0;
    wave_d = wave_q;
    for (int v = 0; v < VOICES; v++) begin
      cnt_d[v] = cnt_q[v];
      div      = note_div(step_q[2:0] + 3'(2 * v));
      if (state_d == StIdle) begin
        cnt_d[v]  = '0;
        wave_d[v] = 1'b0;
      end else if (line_tick) begin
        // >= so a counter left above a shorter new divisor wraps on the next tick.
        if (cnt_q[v] >= div) begin
          cnt_d[v]  = '0;
          wave_d[v] = ~wave_q[v];
        end else begin
          cnt_d[v] = cnt_q[v] + 1'b1;
        end
      end
      pop = pop + MixW'(wave_q[v]);
    end
    mix_d   = gate_open ? pop : '0;
    sound_d = (mix_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      step_q   <= '0;
      frame_q  <= '0;
      tempo_q  <= '0;
      env_q    <= '0;
      strobe_q <= 1'b0;
      wave_q   <= '0;
      mix_q    <= '0;
      sound_q  <= 1'b0;
      for (int v = 0; v < VOICES; v++) cnt_q[v] <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      frame_q  <= frame_d;
      tempo_q  <= tempo_d;
      env_q    <= env_d;
      strobe_q <= strobe_d;
      wave_q   <= wave_d;
      mix_q    <= mix_d;
      sound_q  <= sound_d;
      for (int v = 0; v < VOICES; v++) cnt_q[v] <= cnt_d[v];
    end
  end

  assign voice_wave  = wave_q;
  assign mix         = mix_q;
  assign sound       = sound_q;
  assign step_idx    = step_q;
  assign step_strobe = strobe_q;
  assign env_level   = env_q;
  assign playing     = (state_q != StIdle);

endmodule
